// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad code lock: FSM states, special keys,
// entry buffer length and a small key-class helper.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_OPEN    = 3'd1,
        ST_SETCODE = 3'd2,
        ST_ERR     = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam int         ENTRY_LEN = 4;

    // Scanner codes 0..9 are decimal digits.
    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable 16-bit down-counter. done is high while the count holds 1, i.e.
// in the cycle it steps to 0, so a load of N gives a dwell of exactly N cycles.
module lock_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);

    logic [15:0] count;

    // Load has priority; otherwise count down and park at 0.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 16'd0;
        else if (load)
            count <= load_val;
        else if (count != 16'd0)
            count <= count - 16'd1;
    end

    // Load is deliberately not folded in here so the FSM's load decision
    // never feeds back into its own timeout input.
    assign done = (count == 16'd1);

endmodule

// File: rtl/keypad_code_lock.sv
// 4-digit keypad code lock: press edge detect, entry buffer, code compare,
// timed unlock, failed-attempt lockout and code change while unlocked.
module keypad_code_lock
    import keypad_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter logic [15:0] UNLOCK_TICKS = 16'd50000,
    parameter logic [15:0] ERR_TICKS    = 16'd10000,
    parameter logic [15:0] LOCK_TICKS   = 16'd60000,
    parameter logic [1:0]  MAX_FAIL     = 2'd3
) (
    input  logic        fin,
    input  logic        rst,
    input  logic [3:0]  keycode,
    input  logic        key_pulse,
    output logic        unlock,
    output logic        err,
    output logic        alarm,
    output logic [15:0] entry_digits,
    output logic [2:0]  entry_cnt,
    output logic [2:0]  state_o
);

    state_t      state, state_n;
    logic [15:0] code, code_n;
    logic [15:0] entry_n, buf_d;
    logic [2:0]  cnt_n, buf_c;
    logic [1:0]  fail_cnt, fail_n, fail_inc;
    logic        key_prev, key_ev;
    logic        entry_full;
    logic        tmr_load, tmr_done;
    logic [15:0] tmr_val;

    // One event per press no matter how long the strobe is held.
    assign key_ev     = key_pulse & ~key_prev;
    assign entry_full = (entry_cnt == 3'(ENTRY_LEN));
    assign fail_inc   = fail_cnt + 2'd1;
    assign state_o    = state;

    lock_timer u_timer (
        .clk      (fin),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Entry buffer update for the current key event (digits shift in MSD
    // first, a full buffer ignores further digits, clear empties it).
    always_comb begin
        buf_d = entry_digits;
        buf_c = entry_cnt;
        if (key_ev) begin
            if (is_digit(keycode) && !entry_full) begin
                buf_d = {entry_digits[11:0], keycode};
                buf_c = entry_cnt + 3'd1;
            end else if (keycode == KEY_CLEAR) begin
                buf_d = 16'd0;
                buf_c = 3'd0;
            end
        end
    end

    // Next state, code, fail count, entry buffer and timer load.
    always_comb begin
        state_n  = state;
        code_n   = code;
        fail_n   = fail_cnt;
        entry_n  = entry_digits;
        cnt_n    = entry_cnt;
        tmr_load = 1'b0;
        tmr_val  = 16'd0;
        case (state)
            ST_LOCKED: begin
                entry_n = buf_d;
                cnt_n   = buf_c;
                if (key_ev && keycode == KEY_ENTER) begin
                    entry_n  = 16'd0;
                    cnt_n    = 3'd0;
                    tmr_load = 1'b1;
                    if (entry_full && entry_digits == code) begin
                        state_n = ST_OPEN;
                        fail_n  = 2'd0;
                        tmr_val = UNLOCK_TICKS;
                    end else begin
                        fail_n = fail_inc;
                        if (fail_inc == MAX_FAIL) begin
                            state_n = ST_LOCKOUT;
                            tmr_val = LOCK_TICKS;
                        end else begin
                            state_n = ST_ERR;
                            tmr_val = ERR_TICKS;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (key_ev && keycode == KEY_CLEAR) begin
                    state_n  = ST_LOCKED;
                    tmr_load = 1'b1;
                end else if (key_ev && keycode == KEY_ENTER) begin
                    state_n  = ST_SETCODE;
                    entry_n  = 16'd0;
                    cnt_n    = 3'd0;
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_TICKS;
                end else if (tmr_done) begin
                    state_n = ST_LOCKED;
                end
            end
            ST_SETCODE: begin
                // Any real key (0..11) counts as activity; 12..15 do not.
                if (key_ev && keycode <= KEY_ENTER) begin
                    entry_n  = buf_d;
                    cnt_n    = buf_c;
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_TICKS;
                    if (keycode == KEY_ENTER && entry_full) begin
                        code_n  = entry_digits;
                        entry_n = 16'd0;
                        cnt_n   = 3'd0;
                        state_n = ST_LOCKED;
                        tmr_val = 16'd0;
                    end
                end else if (tmr_done) begin
                    state_n = ST_LOCKED;
                    entry_n = 16'd0;
                    cnt_n   = 3'd0;
                end
            end
            ST_ERR: begin
                if (tmr_done)
                    state_n = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_n = ST_LOCKED;
                    fail_n  = 2'd0;
                end
            end
            default: state_n = ST_LOCKED;
        endcase
    end

    // State and datapath registers; indicator outputs decode the next state
    // so they line up with state_o.
    always_ff @(posedge fin) begin
        if (rst) begin
            state        <= ST_LOCKED;
            code         <= DEFAULT_CODE;
            fail_cnt     <= 2'd0;
            entry_digits <= 16'd0;
            entry_cnt    <= 3'd0;
            key_prev     <= 1'b0;
            unlock       <= 1'b0;
            err          <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state        <= state_n;
            code         <= code_n;
            fail_cnt     <= fail_n;
            entry_digits <= entry_n;
            entry_cnt    <= cnt_n;
            key_prev     <= key_pulse;
            unlock       <= (state_n == ST_OPEN) || (state_n == ST_SETCODE);
            err          <= (state_n == ST_ERR);
            alarm        <= (state_n == ST_LOCKOUT);
        end
    end

endmodule
